// File: rtl/spi_sram_slave_pkg.sv
// Shared constants and types for the SPI SRAM slave.
// Opcodes, mode-field encoding, FSM states and the address-advance helper.
package spi_sram_slave_pkg;

    localparam logic [7:0] OP_WRMR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDMR  = 8'h05;

    // Mode field is bits [7:6]; 11 behaves as sequential.
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;
    localparam logic [1:0] MODE_PAGE = 2'b10;

    localparam logic [7:0] MODE_RESET = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_RDMR,
        ST_WRMR,
        ST_IGNORE
    } state_t;

    function automatic logic [15:0] next_addr(
        input logic [15:0] a,
        input logic [1:0]  m
    );
        if (m == MODE_PAGE)
            return {a[15:5], a[4:0] + 5'd1};
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/spi_sram_slave_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection
// on the synchronized SPI clock.
module spi_slave_sync (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic cs_active,
    output logic clk_rise,
    output logic clk_fall,
    output logic mosi_s
);

    logic [2:0] clk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            clk_q  <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            clk_q  <= {clk_q[1:0], spi_clk};
            cs_q   <= {cs_q[0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign cs_active = ~cs_q[1];
    assign clk_rise  = clk_q[1] & ~clk_q[2];
    assign clk_fall  = ~clk_q[1] & clk_q[2];
    assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_sram_slave.sv
// SPI (mode 0) SRAM slave with READ/WRITE and a byte/page/sequential mode.
// Define SPI_SRAM_SLAVE_MODE_REG_EN to enable the RDMR/WRMR mode register.
import spi_sram_slave_pkg::*;

module spi_sram_slave #(
    parameter int MEM_BYTES = 1024
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic busy
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t state, state_nx;

    logic        cs_active, clk_rise, clk_fall, mosi_s;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [15:0] addr, addr_nx, addr_cat;
    logic        addr_lo, op_read;
    logic [7:0]  tx_sh;
    logic        miso_q;
    logic [1:0]  idle_q;
    logic        armed;
    logic [7:0]  mode_byte;
    logic [1:0]  mode;
    logic [7:0]  mem [MEM_BYTES];

    spi_slave_sync u_sync (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .cs_active (cs_active),
        .clk_rise  (clk_rise),
        .clk_fall  (clk_fall),
        .mosi_s    (mosi_s)
    );

    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = clk_rise && (bit_cnt == 3'd7);
    assign addr_cat  = {addr[15:8], rx_byte};
    assign addr_nx   = next_addr(addr, mode);
    assign mode      = mode_byte[7:6];

`ifdef SPI_SRAM_SLAVE_MODE_REG_EN
    localparam bit MR_EN = 1'b1;
    logic [7:0] mode_r;

    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            mode_r <= MODE_RESET;
        else if (state == ST_WRMR && cs_active && byte_done)
            mode_r <= rx_byte;
    end

    assign mode_byte = mode_r;
`else
    localparam bit MR_EN = 1'b0;
    assign mode_byte = MODE_RESET;
`endif

    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state != ST_IDLE && !cs_active) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:
                    if (cs_active && armed)
                        state_nx = ST_CMD;
                ST_CMD:
                    if (byte_done) begin
                        unique case (1'b1)
                            rx_byte == OP_WRITE,
                            rx_byte == OP_READ:
                                state_nx = ST_ADDR;
                            MR_EN && rx_byte == OP_RDMR:
                                state_nx = ST_RDMR;
                            MR_EN && rx_byte == OP_WRMR:
                                state_nx = ST_WRMR;
                            default:
                                state_nx = ST_IGNORE;
                        endcase
                    end
                ST_ADDR:
                    if (byte_done && addr_lo)
                        state_nx = op_read ? ST_READ : ST_WRITE;
                ST_WRITE, ST_READ:
                    if (byte_done && mode == MODE_BYTE)
                        state_nx = ST_IGNORE;
                ST_WRMR:
                    if (byte_done)
                        state_nx = ST_IGNORE;
                default: ;
            endcase
        end
    end

    always_comb begin
        spi_miso_oe = cs_active && (state == ST_READ || state == ST_RDMR);
        spi_miso    = spi_miso_oe & miso_q;
        busy        = cs_active;
    end

    // A chip select already low when reset releases must not start a
    // transaction: arm only after cs has been seen idle for three cycles.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            idle_q  <= 2'b00;
            armed   <= 1'b0;
            bit_cnt <= 3'd0;
            rx_sh   <= 7'd0;
            addr    <= 16'd0;
            addr_lo <= 1'b0;
            op_read <= 1'b0;
            tx_sh   <= 8'd0;
            miso_q  <= 1'b0;
        end else begin
            idle_q <= {idle_q[0], ~cs_active};
            if (!cs_active && (&idle_q))
                armed <= 1'b1;
            if (state == ST_IDLE || !cs_active) begin
                bit_cnt <= 3'd0;
                rx_sh   <= 7'd0;
                addr    <= 16'd0;
                addr_lo <= 1'b0;
                tx_sh   <= 8'd0;
                miso_q  <= 1'b0;
            end else begin
                if (clk_rise) begin
                    rx_sh   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (clk_fall && (state == ST_READ || state == ST_RDMR)) begin
                    miso_q <= tx_sh[7];
                    tx_sh  <= {tx_sh[6:0], 1'b0};
                end
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            op_read <= (rx_byte == OP_READ);
                            tx_sh   <= mode_byte;
                        end
                        ST_ADDR:
                            if (!addr_lo) begin
                                addr[15:8] <= rx_byte;
                                addr_lo    <= 1'b1;
                            end else begin
                                addr  <= addr_cat;
                                tx_sh <= mem[addr_cat[AW-1:0]];
                            end
                        ST_WRITE:
                            addr <= addr_nx;
                        ST_READ: begin
                            addr  <= addr_nx;
                            tx_sh <= mem[addr_nx[AW-1:0]];
                        end
                        ST_RDMR:
                            tx_sh <= mode_byte;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst && state == ST_WRITE && cs_active && byte_done)
            mem[addr[AW-1:0]] <= rx_byte;
    end

endmodule
